comp_pipe: RTL and testbench
============================

// Module: comp_pipe
// PURPOSE
//   Pipelined, multi-mode magnitude comparator for wide operands. Successor to the
//   single-cycle less-than comparator in the common comparator library.
//   - Resolves CHUNK bits per stage, MSB chunk first; supports signed and unsigned operands.
//   - Selectable relation: EQ, NE, LT, LE, GT, GE.
//   - valid/ready handshake on both sides; full throughput of 1 compare per cycle.
//   - Sits between datapath producers (counters, timers, ADC codes) and threshold/alarm logic.
// PARAMETERS
//   N      16  operand width in bits, >= 2
//   CHUNK   4  bits resolved per pipeline stage, 1..N
//   STAGES  -  localparam = (N+CHUNK-1)/CHUNK, pipeline depth; the top chunk may be narrower
// PORTS
//   clk        in   1      clock, all state updates on rising edge
//   rst        in   1      synchronous reset, active-high
//   in_valid   in   1      a, b, op, is_signed qualify this cycle
//   in_ready   out  1      pipeline accepts input this cycle
//   a          in   N      operand A
//   b          in   N      operand B
//   op         in   3      0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved
//   is_signed  in   1      1: two's-complement compare; 0: unsigned
//   out_valid  out  1      result fields hold a completed compare
//   out_ready  in   1      consumer takes the result this cycle
//   result     out  1      selected relation A op B
//   a_lt_b     out  1      raw A < B, independent of op
//   a_eq_b     out  1      raw A == B, independent of op
//   op_err     out  1      op was reserved (6/7); result forced 0
// BEHAVIOUR
// - Reset: with rst=1 at an edge, all stage valid bits and out_valid clear, and
//   result/a_lt_b/a_eq_b/op_err clear to 0. in_ready=1 in the cycle after reset.
//   Asserting rst mid-operation flushes every in-flight compare; none is delivered.
// - Handshake:
//   - Input transfer when in_valid & in_ready; output transfer when out_valid & out_ready.
//   - stall = out_valid & ~out_ready; in_ready = ~stall (combinational, no comb path from in_valid).
//   - On stall every stage holds; otherwise all stages advance one slot.
//   - Bubbles (invalid slots) advance normally and are not compacted.
//   - Output fields remain stable while out_valid & ~out_ready.
// - Latency: STAGES cycles from input transfer to out_valid=1 with no stall;
//   back-to-back inputs produce back-to-back outputs.
// - Signed mode: the MSB of both a and b is inverted at entry, then everything is compared
//   unsigned. is_signed and op travel with the data.
// - Stage k (k=0 is MSB chunk) carries a decided flag, a lt flag and the unresolved lower bits.
//   - If decided=0 and the chunks differ: decided=1, lt=(chunk_a<chunk_b).
//   - If decided=1: the flags pass through unchanged.
// - Final stage:
//   - a_eq_b = ~decided; a_lt_b = decided & lt.
//   - result per op: EQ=eq, NE=~eq, LT=lt, LE=lt|eq, GT=~lt&~eq, GE=~lt.
//   - op 6/7: result=0, op_err=1; a_lt_b and a_eq_b are still valid.
// - Simultaneous output transfer and input transfer in the same cycle is legal and lossless.
// - No storage beyond STAGES slots; no overflow is possible because input is held off by in_ready.
// TESTING (N=16, CHUNK=4, STAGES=4 unless noted)
// - Reset: rst=1 for 2 cycles with in_valid=1 -> out_valid=0, result=0, in_ready=1 after
//   release; nothing emerges 4 cycles later.
// - Unsigned ops: a=16'h1234, b=16'h1235, op=LT, is_signed=0 -> out_valid exactly 4 cycles
//   after accept, result=1, a_lt_b=1, a_eq_b=0. Same a=b=16'hBEEF, op=LE -> result=1, a_eq_b=1.
// - Signed boundary: a=16'h8000, b=16'h7FFF, op=GT -> is_signed=1: result=0;
//   is_signed=0: result=1. a=16'hFFFF, b=16'h0000, op=LT, signed -> result=1.
// - Backpressure: stream 8 compares back-to-back, hold out_ready=0 for 3 cycles mid-stream ->
//   in_ready=0 during the hold, no result lost or duplicated, output order equals input order,
//   output fields stable during the hold.
// - Reserved op / reset flush: op=7 with a=1, b=2 -> op_err=1, result=0, a_lt_b=1.
//   Then 3 compares in flight and rst pulsed -> zero outputs delivered.
// - Parameter sweep: N=5, CHUNK=2 (STAGES=3, top chunk 1 bit) and N=8, CHUNK=8 (STAGES=1)
//   -> random 10k vectors match a behavioural model for all 6 ops, signed and unsigned.

Source files
------------

// File: rtl/comp_pipe.sv
// ---------------------------------------------------------------------------
// comp_pipe
//   Pipelined multi-mode magnitude comparator. One operand chunk of CHUNK bits
//   is resolved per stage, most significant chunk first. The most significant
//   chunk may be narrower than CHUNK. A new compare can be accepted every cycle.
//   Signed compares invert both MSBs at entry, so every later stage compares
//   unsigned.
//
// Parameters
//   N       operand width (>= 2)
//   CHUNK   bits resolved per stage (1..N)
//
// Ports
//   clk        clock, rising edge
//   rst        synchronous reset, active high; flushes all in-flight compares
//   in_valid   a/b/op/is_signed qualify this cycle
//   in_ready   pipeline accepts input this cycle (low only while output stalls)
//   a, b       operands, N bits
//   op         0 EQ, 1 NE, 2 LT, 3 LE, 4 GT, 5 GE, 6/7 reserved
//   is_signed  1: two's-complement compare, 0: unsigned
//   out_valid  result fields hold a completed compare
//   out_ready  consumer takes the result this cycle
//   result     selected relation "a op b" (0 for reserved op)
//   a_lt_b     raw a < b
//   a_eq_b     raw a == b
//   op_err     op was reserved
// ---------------------------------------------------------------------------
module comp_pipe #(
   parameter int N     = 16,
   parameter int CHUNK = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [N-1:0] a,
   input  logic [N-1:0] b,
   input  logic [2:0]   op,
   input  logic         is_signed,
   output logic         out_valid,
   input  logic         out_ready,
   output logic         result,
   output logic         a_lt_b,
   output logic         a_eq_b,
   output logic         op_err
);

   localparam int STAGES = (N + CHUNK - 1) / CHUNK;
   localparam int TOP_W  = N - (STAGES - 1) * CHUNK;

   logic         stall_s;
   logic         adv_s;
   logic         out_valid_s;
   logic [N-1:0] a_ent_s;
   logic [N-1:0] b_ent_s;
   logic         result_r;
   logic         a_lt_b_r;
   logic         a_eq_b_r;
   logic         op_err_r;

   // Fold one chunk into the {decided, lt} state; once decided, the state is frozen.
   function automatic logic [1:0] resolve(input logic dec_f, input logic lt_f,
                                          input logic [CHUNK-1:0] ca_f,
                                          input logic [CHUNK-1:0] cb_f);
      logic [1:0] r;
      if (dec_f) begin
         r = {1'b1, lt_f};
      end else if (ca_f != cb_f) begin
         r = {1'b1, (ca_f < cb_f)};
      end else begin
         r = 2'b00;
      end
      return r;
   endfunction

   // Map the raw eq/lt pair onto the requested relation.
   function automatic logic select_rel(input logic [2:0] op_f, input logic eq_f,
                                       input logic lt_f);
      logic r;
      case (op_f)
         3'd0:    r = eq_f;
         3'd1:    r = ~eq_f;
         3'd2:    r = lt_f;
         3'd3:    r = lt_f | eq_f;
         3'd4:    r = ~lt_f & ~eq_f;
         3'd5:    r = ~lt_f;
         default: r = 1'b0;
      endcase
      return r;
   endfunction

   // A held output freezes the whole pipe; bubbles move like real slots.
   assign stall_s  = out_valid_s & ~out_ready;
   assign adv_s    = ~stall_s;
   assign in_ready = adv_s;

   // Signed entry mapping: flipping both MSBs turns two's-complement order into unsigned order.
   always_comb begin
      a_ent_s = a;
      b_ent_s = b;
      if (is_signed) begin
         a_ent_s[N-1] = ~a[N-1];
         b_ent_s[N-1] = ~b[N-1];
      end else begin
         a_ent_s[N-1] = a[N-1];
         b_ent_s[N-1] = b[N-1];
      end
   end

   for (genvar k = 0; k < STAGES; k++) begin : stage_g
      logic             v_in_s;
      logic             dec_in_s;
      logic             lt_in_s;
      logic [2:0]       op_in_s;
      logic [CHUNK-1:0] ca_s;
      logic [CHUNK-1:0] cb_s;
      logic [1:0]       res_s;
      logic             valid_r;

      if (k == 0) begin : src_g
         // Entry stage: takes the top chunk straight from the (mapped) inputs, zero-extended.
         always_comb begin
            v_in_s   = in_valid;
            dec_in_s = 1'b0;
            lt_in_s  = 1'b0;
            op_in_s  = op;
            ca_s     = {CHUNK{1'b0}};
            cb_s     = {CHUNK{1'b0}};
            ca_s[TOP_W-1:0] = a_ent_s[N-1 -: TOP_W];
            cb_s[TOP_W-1:0] = b_ent_s[N-1 -: TOP_W];
         end
      end else begin : src_g
         // Later stages: take the top chunk of what the previous slot left unresolved.
         always_comb begin
            v_in_s   = stage_g[k-1].valid_r;
            dec_in_s = stage_g[k-1].mid_g.dec_r;
            lt_in_s  = stage_g[k-1].mid_g.lt_r;
            op_in_s  = stage_g[k-1].mid_g.op_r;
            ca_s     = stage_g[k-1].mid_g.a_rem_r[(STAGES-k)*CHUNK-1 -: CHUNK];
            cb_s     = stage_g[k-1].mid_g.b_rem_r[(STAGES-k)*CHUNK-1 -: CHUNK];
         end
      end

      assign res_s = resolve(dec_in_s, lt_in_s, ca_s, cb_s);

      // Slot occupancy: hold on stall, otherwise copy the upstream slot (bubble or not).
      always_ff @(posedge clk) begin
         if (rst) begin
            valid_r <= 1'b0;
         end else if (adv_s) begin
            valid_r <= v_in_s;
         end
      end

      if (k < STAGES - 1) begin : mid_g
         localparam int REM_W = (STAGES - 1 - k) * CHUNK;
         logic [REM_W-1:0] a_rem_in_s;
         logic [REM_W-1:0] b_rem_in_s;
         logic [REM_W-1:0] a_rem_r;
         logic [REM_W-1:0] b_rem_r;
         logic             dec_r;
         logic             lt_r;
         logic [2:0]       op_r;

         if (k == 0) begin : rin_g
            assign a_rem_in_s = a_ent_s[REM_W-1:0];
            assign b_rem_in_s = b_ent_s[REM_W-1:0];
         end else begin : rin_g
            assign a_rem_in_s = stage_g[k-1].mid_g.a_rem_r[REM_W-1:0];
            assign b_rem_in_s = stage_g[k-1].mid_g.b_rem_r[REM_W-1:0];
         end

         // Intermediate slot payload: partial decision, op and the still-unresolved low bits.
         always_ff @(posedge clk) begin
            if (rst) begin
               dec_r   <= 1'b0;
               lt_r    <= 1'b0;
               op_r    <= 3'd0;
               a_rem_r <= {REM_W{1'b0}};
               b_rem_r <= {REM_W{1'b0}};
            end else if (adv_s) begin
               dec_r   <= res_s[1];
               lt_r    <= res_s[0];
               op_r    <= op_in_s;
               a_rem_r <= a_rem_in_s;
               b_rem_r <= b_rem_in_s;
            end
         end
      end else begin : last_g
         logic eq_s;
         logic lt_fin_s;

         // Undecided after the last chunk means every chunk matched.
         assign eq_s     = ~res_s[1];
         assign lt_fin_s = res_s[1] & res_s[0];

         // Output fields only change when a real compare lands, so they stay put across bubbles and stalls.
         always_ff @(posedge clk) begin
            if (rst) begin
               result_r <= 1'b0;
               a_lt_b_r <= 1'b0;
               a_eq_b_r <= 1'b0;
               op_err_r <= 1'b0;
            end else if (adv_s && v_in_s) begin
               result_r <= select_rel(op_in_s, eq_s, lt_fin_s);
               a_lt_b_r <= lt_fin_s;
               a_eq_b_r <= eq_s;
               op_err_r <= (op_in_s >= 3'd6);
            end
         end
      end
   end

   assign out_valid_s = stage_g[STAGES-1].valid_r;
   assign out_valid   = out_valid_s;
   assign result      = result_r;
   assign a_lt_b      = a_lt_b_r;
   assign a_eq_b      = a_eq_b_r;
   assign op_err      = op_err_r;

endmodule

// File: tb/tb_comp_pipe.sv
// ---------------------------------------------------------------------------
// tb_comp_pipe
//   Directed and random checks of comp_pipe. Three instances: N=16/CHUNK=4
//   for directed tests, N=5/CHUNK=2 and N=8/CHUNK=8 for random sweeps against
//   an integer-arithmetic reference model.
// ---------------------------------------------------------------------------
module tb_comp_pipe;

   logic clk;
   logic rst;

   // main instance (N=16, CHUNK=4)
   logic        m_in_valid, m_in_ready, m_sgn, m_out_valid, m_out_ready;
   logic [15:0] m_a, m_b;
   logic [2:0]  m_op;
   logic        m_result, m_a_lt_b, m_a_eq_b, m_op_err;

   // sweep instance N=5, CHUNK=2
   logic        s5_in_valid, s5_in_ready, s5_sgn, s5_out_valid, s5_out_ready;
   logic [4:0]  s5_a, s5_b;
   logic [2:0]  s5_op;
   logic        s5_result, s5_a_lt_b, s5_a_eq_b, s5_op_err;

   // sweep instance N=8, CHUNK=8
   logic        s8_in_valid, s8_in_ready, s8_sgn, s8_out_valid, s8_out_ready;
   logic [7:0]  s8_a, s8_b;
   logic [2:0]  s8_op;
   logic        s8_result, s8_a_lt_b, s8_a_eq_b, s8_op_err;

   int errors = 0;
   int checks = 0;

   comp_pipe #(.N(16), .CHUNK(4)) dut (
      .clk(clk), .rst(rst), .in_valid(m_in_valid), .in_ready(m_in_ready),
      .a(m_a), .b(m_b), .op(m_op), .is_signed(m_sgn),
      .out_valid(m_out_valid), .out_ready(m_out_ready), .result(m_result),
      .a_lt_b(m_a_lt_b), .a_eq_b(m_a_eq_b), .op_err(m_op_err));

   comp_pipe #(.N(5), .CHUNK(2)) dut5 (
      .clk(clk), .rst(rst), .in_valid(s5_in_valid), .in_ready(s5_in_ready),
      .a(s5_a), .b(s5_b), .op(s5_op), .is_signed(s5_sgn),
      .out_valid(s5_out_valid), .out_ready(s5_out_ready), .result(s5_result),
      .a_lt_b(s5_a_lt_b), .a_eq_b(s5_a_eq_b), .op_err(s5_op_err));

   comp_pipe #(.N(8), .CHUNK(8)) dut8 (
      .clk(clk), .rst(rst), .in_valid(s8_in_valid), .in_ready(s8_in_ready),
      .a(s8_a), .b(s8_b), .op(s8_op), .is_signed(s8_sgn),
      .out_valid(s8_out_valid), .out_ready(s8_out_ready), .result(s8_result),
      .a_lt_b(s8_a_lt_b), .a_eq_b(s8_a_eq_b), .op_err(s8_op_err));

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Reference: interpret operands as integers and apply the relation directly.
   // Returns {result, a_lt_b, a_eq_b, op_err}.
   function automatic logic [3:0] model(input int n, input logic [15:0] ra, input logic [15:0] rb,
                                        input logic [2:0] rop, input logic rsg);
      longint va, vb;
      logic   r;
      va = longint'(ra);
      vb = longint'(rb);
      if (rsg && ra[n-1]) va = va - (longint'(1) << n);
      if (rsg && rb[n-1]) vb = vb - (longint'(1) << n);
      case (rop)
         3'd0:    r = (va == vb);
         3'd1:    r = (va != vb);
         3'd2:    r = (va <  vb);
         3'd3:    r = (va <= vb);
         3'd4:    r = (va >  vb);
         3'd5:    r = (va >= vb);
         default: r = 1'b0;
      endcase
      return {r, (va < vb), (va == vb), (rop >= 3'd6)};
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One isolated compare on the main instance: checks latency and all result fields.
   task automatic one_compare(input string tag, input logic [15:0] ta, input logic [15:0] tb2,
                              input logic [2:0] top, input logic tsg, input logic [3:0] exp_f);
      int lat;
      @(posedge clk); #1;
      m_a = ta; m_b = tb2; m_op = top; m_sgn = tsg;
      m_in_valid = 1'b1; m_out_ready = 1'b1;
      @(posedge clk); #1;
      m_in_valid = 1'b0;
      lat = 1;
      @(negedge clk);
      while (!m_out_valid && lat < 12) begin
         @(posedge clk);
         lat++;
         @(negedge clk);
      end
      check({tag, "_latency"}, lat, 32'd4);
      check({tag, "_fields"}, {m_result, m_a_lt_b, m_a_eq_b, m_op_err}, exp_f);
   endtask

   task automatic rand_main;
      m_a   = 16'($urandom);
      m_b   = ($urandom_range(0, 3) == 0) ? m_a : 16'($urandom);
      m_op  = 3'($urandom_range(0, 5));
      m_sgn = 1'($urandom);
   endtask

   logic [3:0] bq[$];
   logic [3:0] q5[$];
   logic [3:0] q8[$];
   int         c5q[$];
   int         c8q[$];

   initial begin
      int         sent, recv, cyc, seen, hold_cnt;
      logic       accepted, held;
      logic [3:0] snap, exp_f, fields;

      rst = 1'b1;
      m_in_valid = 1'b1; m_a = 16'h0001; m_b = 16'h0002; m_op = 3'd2; m_sgn = 1'b0;
      m_out_ready = 1'b1;
      s5_in_valid = 1'b0; s5_a = 5'd0; s5_b = 5'd0; s5_op = 3'd0; s5_sgn = 1'b0; s5_out_ready = 1'b1;
      s8_in_valid = 1'b0; s8_a = 8'd0; s8_b = 8'd0; s8_op = 3'd0; s8_sgn = 1'b0; s8_out_ready = 1'b1;

      // ---- reset with in_valid held high ----
      @(posedge clk);
      @(posedge clk); #1;
      check("rst_out_valid", m_out_valid, 32'd0);
      check("rst_fields", {m_result, m_a_lt_b, m_a_eq_b, m_op_err}, 32'd0);
      rst = 1'b0;
      m_in_valid = 1'b0;
      @(negedge clk);
      check("rst_in_ready", m_in_ready, 32'd1);
      seen = 0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (m_out_valid) seen++;
      end
      check("rst_nothing_emerges", seen, 32'd0);

      // ---- directed compares ----
      one_compare("lt_unsigned", 16'h1234, 16'h1235, 3'd2, 1'b0, 4'b1100);
      one_compare("le_equal",    16'hBEEF, 16'hBEEF, 3'd3, 1'b0, 4'b1010);
      one_compare("gt_signed",   16'h8000, 16'h7FFF, 3'd4, 1'b1, 4'b0100);
      one_compare("gt_unsigned", 16'h8000, 16'h7FFF, 3'd4, 1'b0, 4'b1000);
      one_compare("lt_signed_m1",16'hFFFF, 16'h0000, 3'd2, 1'b1, 4'b1100);
      one_compare("ne_low_chunk",16'hA5A4, 16'hA5A5, 3'd1, 1'b0, 4'b1100);
      one_compare("reserved_op", 16'h0001, 16'h0002, 3'd7, 1'b0, 4'b0101);

      // ---- backpressure: 8 back-to-back, 3-cycle hold ----
      @(posedge clk); #1;
      sent = 0; recv = 0; cyc = 0; held = 1'b0; hold_cnt = 0; snap = 4'd0;
      rand_main();
      m_in_valid = 1'b1;
      while (recv < 8 && cyc < 60) begin
         m_out_ready = !(cyc >= 6 && cyc <= 8);
         @(negedge clk);
         fields = {m_result, m_a_lt_b, m_a_eq_b, m_op_err};
         if (m_out_valid && !m_out_ready) begin
            hold_cnt++;
            check("bp_in_ready_low", m_in_ready, 32'd0);
            if (!held) begin
               snap = fields;
               held = 1'b1;
            end else begin
               check("bp_fields_stable", fields, snap);
            end
         end
         accepted = m_in_valid && m_in_ready;
         if (accepted) begin
            bq.push_back(model(16, m_a, m_b, m_op, m_sgn));
            sent++;
         end
         if (m_out_valid && m_out_ready) begin
            if (bq.size() == 0) begin
               check("bp_underflow", bq.size(), 32'd1);
            end else begin
               exp_f = bq.pop_front();
               check("bp_data_order", fields, exp_f);
            end
            recv++;
         end
         @(posedge clk); #1;
         cyc++;
         if (accepted) begin
            if (sent < 8) rand_main();
            else m_in_valid = 1'b0;
         end
      end
      m_in_valid = 1'b0;
      m_out_ready = 1'b1;
      check("bp_hold_cycles", hold_cnt, 32'd3);
      check("bp_recv_count", recv, 32'd8);
      check("bp_sent_count", sent, 32'd8);
      check("bp_queue_empty", bq.size(), 32'd0);

      // ---- reset flush: 3 in flight, then rst ----
      repeat (6) @(posedge clk);
      #1;
      m_in_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         rand_main();
         @(posedge clk); #1;
      end
      m_in_valid = 1'b0;
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      seen = 0;
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         if (m_out_valid) seen++;
      end
      check("flush_zero_outputs", seen, 32'd0);
      check("flush_in_ready", m_in_ready, 32'd1);

      // ---- parameter sweep: random vectors vs model, with latency ----
      @(posedge clk); #1;
      for (int c = 0; c < 10010; c++) begin
         if (c < 10000) begin
            s5_a   = 5'($urandom);
            s5_b   = ($urandom_range(0, 3) == 0) ? s5_a : 5'($urandom);
            s5_op  = 3'($urandom);
            s5_sgn = 1'($urandom);
            s5_in_valid = ($urandom_range(0, 9) != 0);
            s8_a   = 8'($urandom);
            s8_b   = ($urandom_range(0, 3) == 0) ? s8_a : 8'($urandom);
            s8_op  = 3'($urandom);
            s8_sgn = 1'($urandom);
            s8_in_valid = ($urandom_range(0, 9) != 0);
         end else begin
            s5_in_valid = 1'b0;
            s8_in_valid = 1'b0;
         end
         @(negedge clk);
         if (s5_in_valid && s5_in_ready) begin
            q5.push_back(model(5, {11'd0, s5_a}, {11'd0, s5_b}, s5_op, s5_sgn));
            c5q.push_back(c);
         end
         if (s8_in_valid && s8_in_ready) begin
            q8.push_back(model(8, {8'd0, s8_a}, {8'd0, s8_b}, s8_op, s8_sgn));
            c8q.push_back(c);
         end
         if (s5_out_valid) begin
            if (q5.size() == 0) begin
               check("n5_underflow", q5.size(), 32'd1);
            end else begin
               exp_f = q5.pop_front();
               check("n5_fields", {s5_result, s5_a_lt_b, s5_a_eq_b, s5_op_err}, exp_f);
               check("n5_latency", c - c5q.pop_front(), 32'd3);
            end
         end
         if (s8_out_valid) begin
            if (q8.size() == 0) begin
               check("n8_underflow", q8.size(), 32'd1);
            end else begin
               exp_f = q8.pop_front();
               check("n8_fields", {s8_result, s8_a_lt_b, s8_a_eq_b, s8_op_err}, exp_f);
               check("n8_latency", c - c8q.pop_front(), 32'd1);
            end
         end
         @(posedge clk); #1;
      end
      check("n5_queue_empty", q5.size(), 32'd0);
      check("n8_queue_empty", q8.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
